// File: rtl/param_memory_pkg.sv
// Shared types and constants for the parameterised memory and its clear sequencer.
package mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

endpackage

// File: rtl/param_memory_if.sv
// Request/response bundle of param_memory; the requester drives through master.
interface param_memory_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) ();

  logic                  clearReq;
  logic                  writeEnable;
  logic [ADDR_WIDTH-1:0] writeAddr;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  readEnable;
  logic [ADDR_WIDTH-1:0] readAddr;
  logic [DATA_WIDTH-1:0] readData;
  logic                  readValid;
  logic                  busy;
  logic                  addrError;

  modport master (
    output clearReq, writeEnable, writeAddr, writeData, readEnable, readAddr,
    input  readData, readValid, busy, addrError
  );

  modport slave (
    input  clearReq, writeEnable, writeAddr, writeData, readEnable, readAddr,
    output readData, readValid, busy, addrError
  );

endinterface

// File: rtl/param_memory_clear_ctrl.sv
// Clear sequencer: sweeps every word once after reset or on request, one word per cycle.
module mem_clear_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_req_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // clear_req_i is only looked at in IDLE, so a running sweep cannot be restarted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_o     = (state_q == CLEAR);
    clr_we_o   = (state_q == CLEAR);
    clr_addr_o = cnt_q;
  end

endmodule

// File: rtl/param_memory.sv
// Single-clock dual-port memory with range checking, selectable collision mode and a clear sweep.
module param_memory
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 4096,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter int                    RD_MODE    = RD_FIRST,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clearReq,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  readEnable,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  readValid,
  output logic                  busy,
  output logic                  addrError
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  clr_busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  wr_in_range, rd_in_range;
  logic                  wr_acc, rd_acc, collide;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  addr_err_q, addr_err_d;

  mem_clear_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_ctrl (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_req_i (clearReq),
    .busy_o      (clr_busy),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  always_comb begin
    wr_in_range = ({1'b0, writeAddr} < DEPTH_W);
    rd_in_range = ({1'b0, readAddr} < DEPTH_W);
    wr_acc      = !clr_busy && writeEnable && wr_in_range;
    rd_acc      = !clr_busy && readEnable && rd_in_range;
    collide     = wr_acc && (writeAddr == readAddr);

    // The sweep owns the single write port for its whole duration.
    mem_we    = clr_busy ? clr_we     : wr_acc;
    mem_waddr = clr_busy ? clr_addr   : writeAddr;
    mem_wdata = clr_busy ? INIT_VALUE : writeData;

    rd_data_d = rd_data_q;
    if (rd_acc) begin
      if ((RD_MODE == WR_FIRST) && collide) rd_data_d = writeData;
      else                                  rd_data_d = mem_q[readAddr];
    end
    rd_valid_d = rd_acc;
    addr_err_d = !clr_busy && ((readEnable && !rd_in_range) ||
                               (writeEnable && !wr_in_range));
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    readData  = rd_data_q;
    readValid = rd_valid_q;
    addrError = addr_err_q;
    busy      = clr_busy;
  end

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory (DEPTH 12, INIT 8'hA5) with a cycle model checking both collision modes.
module tb_param_memory;
  import mem_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam logic [DW-1:0] INIT = 8'hA5;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  param_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [DW-1:0] wf_data;
  logic          wf_valid, wf_busy, wf_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  param_memory #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .RD_MODE    (RD_FIRST),
    .INIT_VALUE (INIT)
  ) dut_rf (
    .clock       (clock),
    .reset_n     (reset_n),
    .clearReq    (bus.clearReq),
    .writeEnable (bus.writeEnable),
    .writeAddr   (bus.writeAddr),
    .writeData   (bus.writeData),
    .readEnable  (bus.readEnable),
    .readAddr    (bus.readAddr),
    .readData    (bus.readData),
    .readValid   (bus.readValid),
    .busy        (bus.busy),
    .addrError   (bus.addrError)
  );

  param_memory #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .RD_MODE    (WR_FIRST),
    .INIT_VALUE (INIT)
  ) dut_wf (
    .clock       (clock),
    .reset_n     (reset_n),
    .clearReq    (bus.clearReq),
    .writeEnable (bus.writeEnable),
    .writeAddr   (bus.writeAddr),
    .writeData   (bus.writeData),
    .readEnable  (bus.readEnable),
    .readAddr    (bus.readAddr),
    .readData    (wf_data),
    .readValid   (wf_valid),
    .busy        (wf_busy),
    .addrError   (wf_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Model: words remaining in the sweep, the array contents, and the expected registered outputs.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] m_data_rf, m_data_wf;
  logic          m_valid, m_err;
  int            m_left, m_idx;
  bit            model_ready = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    bit rd_ok, wr_ok;
    if (!reset_n) begin
      m_data_rf   = '0;
      m_data_wf   = '0;
      m_valid     = 1'b0;
      m_err       = 1'b0;
      m_left      = DEPTH;
      m_idx       = 0;
      model_ready = 1'b1;
    end else if (m_left > 0) begin
      mem_m[m_idx] = INIT;
      m_idx++;
      m_left--;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      rd_ok   = bus.readEnable  && (int'(bus.readAddr)  < DEPTH);
      wr_ok   = bus.writeEnable && (int'(bus.writeAddr) < DEPTH);
      m_err   = (bus.readEnable && !rd_ok) || (bus.writeEnable && !wr_ok);
      m_valid = rd_ok;
      if (rd_ok) begin
        m_data_rf = mem_m[int'(bus.readAddr)];
        m_data_wf = (wr_ok && bus.writeAddr == bus.readAddr) ? bus.writeData
                                                             : mem_m[int'(bus.readAddr)];
      end
      if (wr_ok) mem_m[int'(bus.writeAddr)] = bus.writeData;
      if (bus.clearReq) begin
        m_left = DEPTH;
        m_idx  = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (model_ready) begin
      check("busy",       32'(bus.busy),      32'(m_left > 0));
      check("readValid",  32'(bus.readValid), 32'(m_valid));
      check("addrError",  32'(bus.addrError), 32'(m_err));
      check("readData",   32'(bus.readData),  32'(m_data_rf));
      check("wf_busy",    32'(wf_busy),       32'(m_left > 0));
      check("wf_valid",   32'(wf_valid),      32'(m_valid));
      check("wf_err",     32'(wf_err),        32'(m_err));
      check("wf_data",    32'(wf_data),       32'(m_data_wf));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    bus.clearReq    = 1'b0;
    bus.writeEnable = 1'b0;
    bus.readEnable  = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'd12);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.clearReq    = 1'b0;
    bus.writeEnable = 1'b0;
    bus.writeAddr   = '0;
    bus.writeData   = '0;
    bus.readEnable  = 1'b0;
    bus.readAddr    = '0;

    repeat (3) @(posedge clock);
    #2;
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_data", 32'(bus.readData), 32'd0);
    reset_n = 1'b1;
    count_busy("sweep_len_initial");

    for (int i = 0; i < DEPTH; i++) begin
      bus.readEnable = 1'b1;
      bus.readAddr   = AW'(i);
      tick();
      check("init_read_data",  32'(bus.readData),  32'hA5);
      check("init_read_valid", 32'(bus.readValid), 32'd1);
    end
    idle_inputs();

    bus.writeEnable = 1'b1; bus.writeAddr = 4'd5; bus.writeData = 8'h3C;
    tick();
    idle_inputs();
    bus.readEnable = 1'b1; bus.readAddr = 4'd5;
    tick();
    idle_inputs();
    check("wr_rd_data",  32'(bus.readData),  32'h3C);
    check("wr_rd_valid", 32'(bus.readValid), 32'd1);
    tick();
    check("hold_data",  32'(bus.readData),  32'h3C);
    check("hold_valid", 32'(bus.readValid), 32'd0);

    bus.writeEnable = 1'b1; bus.writeAddr = 4'd3; bus.writeData = 8'h77;
    bus.readEnable  = 1'b1; bus.readAddr  = 4'd3;
    tick();
    idle_inputs();
    check("collide_rd_first", 32'(bus.readData), 32'hA5);
    check("collide_wr_first", 32'(wf_data),      32'h77);

    bus.writeEnable = 1'b1; bus.writeAddr = 4'd13; bus.writeData = 8'hFF;
    tick();
    idle_inputs();
    check("oob_wr_err",   32'(bus.addrError), 32'd1);
    check("oob_wr_valid", 32'(bus.readValid), 32'd0);
    bus.readEnable = 1'b1; bus.readAddr = 4'd13;
    tick();
    idle_inputs();
    check("oob_rd_err",   32'(bus.addrError), 32'd1);
    check("oob_rd_valid", 32'(bus.readValid), 32'd0);
    tick();
    check("oob_err_clear", 32'(bus.addrError), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.readEnable = 1'b1;
      bus.readAddr   = AW'(i);
      tick();
    end
    idle_inputs();

    bus.writeEnable = 1'b1; bus.writeAddr = 4'd2; bus.writeData = 8'h11;
    tick();
    idle_inputs();
    bus.clearReq = 1'b1;
    tick();
    idle_inputs();
    n = 0;
    while (bus.busy && n < 50) begin
      idle_inputs();
      if (n == 1) begin
        bus.writeEnable = 1'b1; bus.writeAddr = 4'd2; bus.writeData = 8'h22;
        bus.readEnable  = 1'b1; bus.readAddr  = 4'd2;
      end
      if (n == 4) bus.clearReq = 1'b1;
      tick();
      n++;
    end
    idle_inputs();
    check("clear_busy_len", 32'(n), 32'd12);
    bus.readEnable = 1'b1; bus.readAddr = 4'd2;
    tick();
    idle_inputs();
    check("clear_addr2", 32'(bus.readData), 32'hA5);

    bus.writeEnable = 1'b1; bus.writeAddr = 4'd7; bus.writeData = 8'h5A;
    tick();
    idle_inputs();
    bus.readEnable = 1'b1; bus.readAddr = 4'd7;
    tick();
    idle_inputs();
    check("pre_reset_data", 32'(bus.readData), 32'h5A);
    bus.clearReq = 1'b1;
    tick();
    idle_inputs();
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_data",  32'(bus.readData),  32'd0);
    check("midrst_valid", 32'(bus.readValid), 32'd0);
    check("midrst_err",   32'(bus.addrError), 32'd0);
    check("midrst_busy",  32'(bus.busy),      32'd1);
    tick();
    tick();
    reset_n = 1'b1;
    count_busy("sweep_len_after_reset");
    bus.readEnable = 1'b1; bus.readAddr = 4'd7;
    tick();
    idle_inputs();
    check("post_reset_addr7", 32'(bus.readData), 32'hA5);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4096, number of words; any value >= 2 is legal, including non-powers-of-two.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter RD_MODE, default 0: 0 = read-first, 1 = write-first on same-address collision.
REQ-005 SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH-bit value written by every clear sweep.
REQ-006 SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-008 SHALL have port clearReq, input, 1 bit: request a full clear sweep.
REQ-009 SHALL have port writeEnable, input, 1 bit: write request.
REQ-010 SHALL have port writeAddr, input, ADDR_WIDTH bits: write address.
REQ-011 SHALL have port writeData, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port readEnable, input, 1 bit: read request.
REQ-013 SHALL have port readAddr, input, ADDR_WIDTH bits: read address.
REQ-014 SHALL have port readData, output, DATA_WIDTH bits: registered read data.
REQ-015 SHALL have port readValid, output, 1 bit: readData was updated by the previous cycle's accepted read.
REQ-016 SHALL have port busy, output, 1 bit: clear sweep in progress.
REQ-017 SHALL have port addrError, output, 1 bit: previous cycle carried an out-of-range request.

Function
REQ-018 SHALL implement FSM states IDLE and CLEAR.
REQ-019 SHALL, in CLEAR, write INIT_VALUE to one location per cycle at sweep counter 0..DEPTH-1, then enter IDLE on the cycle after the write to DEPTH-1.
REQ-020 SHALL drive busy = 1 exactly while the state is CLEAR, giving exactly DEPTH busy cycles per sweep.
REQ-021 SHALL, on clearReq in IDLE, enter CLEAR on the next edge with the counter at 0.
REQ-022 SHALL ignore clearReq while in CLEAR; a sweep is never restarted or extended by clearReq.
REQ-023 SHALL ignore readEnable and writeEnable while busy: no array write, readValid = 0, addrError = 0.
REQ-024 SHALL, for a read accepted in IDLE with readAddr < DEPTH, present the data on readData with readValid = 1 on the next cycle (1-cycle latency).
REQ-025 SHALL hold readData unchanged and drive readValid = 0 in any cycle following no accepted read.
REQ-026 SHALL, for a write accepted in IDLE with writeAddr < DEPTH, update the array at that edge.
REQ-027 SHALL resolve a simultaneous read and write to the same address as follows: RD_MODE = 0 returns the old data; RD_MODE = 1 returns writeData.
REQ-028 SHALL suppress any accepted request with an address >= DEPTH: no write, no readValid, and addrError = 1 on the next cycle for one cycle per offending cycle.
REQ-029 SHALL execute a read and a write to different addresses in the same cycle independently.

Reset
REQ-030 SHALL, while reset_n = 0, asynchronously force: readData = 0, readValid = 0, addrError = 0, counter = 0, state = CLEAR, busy = 1.
REQ-031 SHALL start the sweep on the first rising edge after reset_n deasserts.
REQ-032 SHALL NOT reset the storage array directly; its contents are defined only by the sweep.
REQ-033 SHALL, when reset asserts mid-sweep or mid-access, abandon the operation and restart the sweep from address 0.

Structure
REQ-034 SHALL place the FSM state enum and the RD_MODE constants (RD_FIRST, WR_FIRST) in shared package mem_pkg.
REQ-035 SHALL implement the clear sequencer (state, counter, busy) as sub-module mem_clear_ctrl; the array and port logic live in param_memory.

Verification (DATA_WIDTH = 8, DEPTH = 12, INIT_VALUE = 8'hA5 unless stated)
REQ-036 SHALL cover post-reset sweep: release reset_n -> busy high for exactly 12 cycles; afterwards, reads of addresses 0..11 each return 8'hA5 with readValid one cycle after the request.
REQ-037 SHALL cover write then read: write 8'h3C to address 5, read address 5 on the next cycle -> readData = 8'h3C, readValid = 1, one cycle later.
REQ-038 SHALL cover collision: read and write of 8'h77 to address 3 in the same cycle over old value 8'hA5 -> 8'hA5 with RD_MODE = 0, 8'h77 with RD_MODE = 1.
REQ-039 SHALL cover out-of-range access: write address 13 with 8'hFF, then read address 13 -> addrError pulses after each request, readValid stays 0, and no in-range location changes.
REQ-040 SHALL cover clear and requests during busy: write 8'h11 to address 2, then pulse clearReq; during busy, issue a write of 8'h22 to address 2 and a second clearReq -> busy lasts exactly 12 cycles, and address 2 then reads 8'hA5.
REQ-041 SHALL cover reset mid-sweep: assert reset_n low at sweep cycle 6 -> outputs go to reset values immediately; after release, busy lasts a full 12 cycles.
